// File: rtl/pcs_pkg.sv
// Shared definitions for the PCS transmit path: symbol width, comma symbol
// and the serializer state encoding.
package pcs_pkg;

  localparam int SYM_WIDTH = 10;
  localparam logic [SYM_WIDTH-1:0] K28_5_RDN = 10'h17C;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/pcs_tx_serializer.sv
// Link-clock transmit serializer: pulls FWFT symbols, shifts them out LSB first,
// sends a comma preamble after enable and fills FIFO underruns with commas.
module pcs_tx_serializer
  import pcs_pkg::*;
#(
  parameter int                    DATA_WIDTH   = SYM_WIDTH,
  parameter logic [DATA_WIDTH-1:0] IDLE_SYMBOL  = DATA_WIDTH'(K28_5_RDN),
  parameter int                    SYNC_SYMBOLS = 8,
  parameter int                    CNT_WIDTH    = 16
) (
  input  logic                  clk_link,
  input  logic                  rst_link,
  input  logic                  tx_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  tx_bit,
  output logic                  link_up,
  output logic                  idle_ins,
  output logic [CNT_WIDTH-1:0]  idle_ins_cnt
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam int SW = $clog2(SYNC_SYMBOLS + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);
  localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_SYMBOLS);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  tx_state_e             state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [BW-1:0]         bit_cnt;
  logic [SW-1:0]         sync_cnt;
  logic                  load;
  logic                  run_rule;
  logic                  pop;
  logic                  fill;

  // The boundary that ends the last preamble comma already behaves like RUN.
  assign load     = (state != OFF) && (bit_cnt == LAST_BIT);
  assign run_rule = (state == RUN) || ((state == SYNC) && (sync_cnt == SYNC_LAST));
  assign pop      = load && tx_en && run_rule && !fifo_empty;
  assign fill     = load && tx_en && run_rule && fifo_empty;

  assign fifo_rd_en = pop;
  assign tx_bit     = shift_reg[0];

  always_ff @(posedge clk_link or posedge rst_link) begin
    if (rst_link) begin
      state        <= OFF;
      shift_reg    <= '0;
      bit_cnt      <= LAST_BIT;
      sync_cnt     <= '0;
      link_up      <= 1'b0;
      idle_ins     <= 1'b0;
      idle_ins_cnt <= '0;
    end else begin
      idle_ins <= fill;
      if (fill) begin
        idle_ins_cnt <= sat_inc(idle_ins_cnt);
      end

      case (state)
        OFF: begin
          if (tx_en) begin
            state     <= SYNC;
            shift_reg <= IDLE_SYMBOL;
            bit_cnt   <= '0;
            sync_cnt  <= SW'(1);
          end
        end
        default: begin
          if (!load) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + BW'(1);
          end else if (!tx_en) begin
            // Shutdown only takes effect once the current symbol is complete.
            state     <= OFF;
            link_up   <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= LAST_BIT;
            sync_cnt  <= '0;
          end else begin
            bit_cnt <= '0;
            if (run_rule) begin
              state     <= RUN;
              link_up   <= 1'b1;
              shift_reg <= fifo_empty ? IDLE_SYMBOL : fifo_data;
            end else begin
              shift_reg <= IDLE_SYMBOL;
              sync_cnt  <= sync_cnt + SW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcs_tx_serializer.sv
// Directed bench for pcs_tx_serializer with a queue-based FWFT FIFO model;
// a second instance with a 4-bit counter shares the stimulus.
module tb_pcs_tx_serializer;

  localparam logic [9:0] IDLE = 10'h17C;

  logic        clk_link = 1'b0;
  logic        rst_link;
  logic        tx_en;
  logic [9:0]  fifo_data;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        tx_bit;
  logic        link_up;
  logic        idle_ins;
  logic [15:0] idle_ins_cnt;
  logic        fifo_rd_en4;
  logic        tx_bit4;
  logic        link_up4;
  logic        idle_ins4;
  logic [3:0]  idle_ins_cnt4;

  always #5 clk_link = ~clk_link;

  pcs_tx_serializer dut (
    .clk_link    (clk_link),
    .rst_link    (rst_link),
    .tx_en       (tx_en),
    .fifo_data   (fifo_data),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .tx_bit      (tx_bit),
    .link_up     (link_up),
    .idle_ins    (idle_ins),
    .idle_ins_cnt(idle_ins_cnt)
  );

  pcs_tx_serializer #(.CNT_WIDTH(4)) dut4 (
    .clk_link    (clk_link),
    .rst_link    (rst_link),
    .tx_en       (tx_en),
    .fifo_data   (fifo_data),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en4),
    .tx_bit      (tx_bit4),
    .link_up     (link_up4),
    .idle_ins    (idle_ins4),
    .idle_ins_cnt(idle_ins_cnt4)
  );

  int         nvec = 0;
  int         nerr = 0;
  int         cycle = 0;
  int         pops_in_win = 0;
  int         diverge = 0;
  logic       last_rd = 1'b0;
  logic [9:0] q[$];
  int         pc[$];

  // Both instances must serialize identically; only the counter width differs.
  always @(negedge clk_link) begin
    if ((tx_bit4 !== tx_bit) || (link_up4 !== link_up) || (fifo_rd_en4 !== fifo_rd_en))
      diverge++;
  end

  typedef struct {
    logic [9:0]  sym;
    logic        idle;
    logic [15:0] cnt;
    logic        push;
    logic [9:0]  pdata;
    logic        pop;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic upd_fifo();
    fifo_empty = (q.size() == 0);
    fifo_data  = fifo_empty ? 10'h3FF : q[0];
  endtask

  task automatic cyc();
    logic rd;
    @(negedge clk_link);
    rd = fifo_rd_en;
    @(posedge clk_link);
    #1;
    cycle++;
    last_rd = rd;
    if (rd) begin
      pops_in_win++;
      pc.push_back(cycle);
      if (q.size() > 0) void'(q.pop_front());
    end
    upd_fifo();
  endtask

  task automatic collect(output logic [9:0] sym);
    for (int i = 0; i < 10; i++) begin
      sym[i] = tx_bit;
      cyc();
    end
  endtask

  initial begin
    logic [9:0] got;
    logic       any;
    int         pulses;

    tbl[0] = '{IDLE,   1'b1, 16'd1, 1'b1, 10'h2AA, 1'b1};
    tbl[1] = '{10'h2AA, 1'b0, 16'd1, 1'b1, 10'h0FF, 1'b1};
    tbl[2] = '{10'h0FF, 1'b0, 16'd1, 1'b0, 10'h000, 1'b0};
    tbl[3] = '{IDLE,   1'b1, 16'd2, 1'b1, 10'h155, 1'b1};
    tbl[4] = '{10'h155, 1'b0, 16'd2, 1'b1, 10'h3C1, 1'b1};
    tbl[5] = '{10'h3C1, 1'b0, 16'd2, 1'b0, 10'h000, 1'b0};
    tbl[6] = '{IDLE,   1'b1, 16'd3, 1'b0, 10'h000, 1'b0};
    tbl[7] = '{IDLE,   1'b1, 16'd4, 1'b1, 10'h0F0, 1'b1};

    // Reset with enable high and a non-empty FIFO.
    rst_link = 1'b1;
    tx_en    = 1'b1;
    q.push_back(10'h2AA);
    upd_fifo();
    #1;
    check("reset tx_bit", 32'(tx_bit), 0);
    check("reset link_up", 32'(link_up), 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("reset rd_en", 32'(last_rd), 0);
      check("reset tx_bit/link_up/idle_ins", {29'd0, tx_bit, link_up, idle_ins}, 0);
      check("reset idle_ins_cnt", 32'(idle_ins_cnt), 0);
    end

    rst_link = 1'b0;
    q.delete();
    upd_fifo();
    cyc();

    // Preamble: eight commas with the FIFO empty.
    pops_in_win = 0;
    for (int k = 0; k < 8; k++) begin
      check("preamble link_up", 32'(link_up), 0);
      collect(got);
      check("preamble symbol", 32'(got), 32'(IDLE));
    end
    check("preamble pops", pops_in_win, 0);
    check("run link_up", 32'(link_up), 1);

    // Symbol-level table: each record starts at bit 0 of a symbol.
    pc.delete();
    for (int r = 0; r < 8; r++) begin
      check($sformatf("vec%0d idle_ins", r), 32'(idle_ins), 32'(tbl[r].idle));
      check($sformatf("vec%0d idle_ins_cnt", r), 32'(idle_ins_cnt), 32'(tbl[r].cnt));
      if (tbl[r].push) q.push_back(tbl[r].pdata);
      upd_fifo();
      pops_in_win = 0;
      collect(got);
      check($sformatf("vec%0d symbol", r), 32'(got), 32'(tbl[r].sym));
      check($sformatf("vec%0d pops", r), pops_in_win, 32'(tbl[r].pop));
    end
    if (pc.size() >= 2) check("pop spacing", pc[1] - pc[0], 10);
    else check("pop spacing count", pc.size(), 2);
    check("after table idle_ins", 32'(idle_ins), 0);
    check("after table cnt", 32'(idle_ins_cnt), 4);

    // Shutdown during bit 3 of 10'h0F0 with another symbol waiting.
    q.push_back(10'h333);
    upd_fifo();
    pops_in_win = 0;
    for (int i = 0; i < 10; i++) begin
      got[i] = tx_bit;
      if (i == 3) tx_en = 1'b0;
      cyc();
    end
    check("shutdown symbol", 32'(got), 32'h0F0);
    check("shutdown pops", pops_in_win, 0);
    check("shutdown fifo depth", q.size(), 1);
    check("shutdown link_up", 32'(link_up), 0);
    any = 1'b0;
    for (int i = 0; i < 5; i++) begin
      any |= tx_bit;
      cyc();
    end
    check("off tx_bit", 32'(any), 0);
    check("off pops", pops_in_win, 0);

    // Re-enable: fresh preamble, then the waiting symbol.
    tx_en = 1'b1;
    cyc();
    for (int k = 0; k < 8; k++) begin
      check("re-preamble link_up", 32'(link_up), 0);
      collect(got);
      check("re-preamble symbol", 32'(got), 32'(IDLE));
    end
    check("re-run pop", 32'(last_rd), 1);
    check("re-run link_up", 32'(link_up), 1);
    check("re-run idle_ins", 32'(idle_ins), 0);

    // A short tx_en dip inside a symbol must not stop the link.
    for (int i = 0; i < 10; i++) begin
      got[i] = tx_bit;
      if (i == 2) tx_en = 1'b0;
      if (i == 5) tx_en = 1'b1;
      cyc();
    end
    check("cancel symbol", 32'(got), 32'h333);
    check("cancel link_up", 32'(link_up), 1);
    check("cancel idle_ins", 32'(idle_ins), 1);
    check("cancel cnt", 32'(idle_ins_cnt), 5);
    check("cnt4 before sat", 32'(idle_ins_cnt4), 5);

    // Twenty underrun symbols: the 4-bit counter saturates, pulses continue.
    pulses = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (idle_ins4) pulses++;
    end
    check("sat pulses", pulses, 20);
    check("sat cnt4", 32'(idle_ins_cnt4), 15);
    check("wide cnt", 32'(idle_ins_cnt), 25);
    check("instance divergence", diverge, 0);

    // Asynchronous reset in the middle of a symbol.
    q.push_back(10'h2AA);
    upd_fifo();
    cyc();
    cyc();
    check("pre-reset link_up", 32'(link_up), 1);
    #2;
    rst_link = 1'b1;
    #1;
    check("async rst outputs", {28'd0, tx_bit, link_up, idle_ins, fifo_rd_en}, 0);
    check("async rst cnt", 32'(idle_ins_cnt), 0);
    check("async rst cnt4", 32'(idle_ins_cnt4), 0);
    cyc();
    check("held rst rd_en", 32'(last_rd), 0);
    rst_link = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
